// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package riscv_mem_pkg;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;

    typedef enum logic {
        DPRIO  = 1'b0,
        IFORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = OWN_NONE,
        FETCH = OWN_FETCH,
        DATA  = OWN_DATA
    } resp_owner_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported synchronous RAM between fetch and data ports,
// data first with bounded fetch starvation, and routes read data back.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [AW-1:0]      i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic [DW-1:0]      i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [AW-1:0]      d_addr,
    input  logic [DW-1:0]      d_wdata,
    input  logic [DW/8-1:0]    d_be,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [DW-1:0]      d_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic [DW/8-1:0]    mem_be,
    input  logic [DW-1:0]      mem_rdata,
    input  logic               perf_clr,
    output logic [CNT_W-1:0]   conflicts
);

    localparam int unsigned SW = cnt_width(MAX_DSTREAK);

    arb_state_t  state, state_next;
    resp_owner_t owner, owner_next;
    logic [SW-1:0] streak, streak_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= DPRIO;
            owner  <= NONE;
            streak <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            streak <= streak_next;
        end
    end

    // Grant, starvation tracking and response ownership.
    always_comb begin
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        state_next  = state;
        streak_next = streak;
        owner_next  = NONE;

        if (i_req && d_req) begin
            if (state == IFORCE) i_gnt = 1'b1;
            else                 d_gnt = 1'b1;
        end else begin
            i_gnt = i_req;
            d_gnt = d_req;
        end

        if (i_gnt || !i_req) begin
            streak_next = '0;
        end else if (d_gnt && (streak != SW'(MAX_DSTREAK))) begin
            streak_next = streak + SW'(1);
        end

        case (state)
            DPRIO:  if (d_gnt && i_req && (streak_next == SW'(MAX_DSTREAK))) state_next = IFORCE;
            IFORCE: if (i_gnt) state_next = DPRIO;
            default: state_next = DPRIO;
        endcase

        if (i_gnt)              owner_next = FETCH;
        else if (d_gnt && !d_we) owner_next = DATA;
    end

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_wdata;
    assign mem_be    = mem_we ? d_be : '1;

    assign i_rvalid = (owner == FETCH);
    assign d_rvalid = (owner == DATA);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    sat_counter #(.W(CNT_W)) u_conflicts (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .inc   (i_req & d_req),
        .count (conflicts)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural single-port RAM.
module tb_unified_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt, i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            d_req, d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [3:0]      d_be;
    logic            d_gnt, d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [3:0]      mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            perf_clr;
    logic [CW-1:0]   conflicts;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [0:1023];

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .perf_clr(perf_clr), .conflicts(conflicts)
    );

    // Synchronous single-port RAM with byte-enabled writes and 1-cycle reads.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[11:2]];
            end
        end
    end

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        perf_clr = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data; d_be = be;
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        i_req = 1'b1;
        #1;
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt: i_gnt=%b d_gnt=%b mem_en=%b mem_we=%b expected 1 0 1 0",
                     i_gnt, d_gnt, mem_en, mem_we);
        end
        @(posedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || conflicts !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: i_rvalid=%b d_rvalid=%b conflicts=%0d expected 0 0 0",
                     i_rvalid, d_rvalid, conflicts);
        end
        @(negedge clk);
        reset = 1'b0;
        i_req = 1'b0;
        #1;
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_gnt: i_gnt=%b d_gnt=%b mem_en=%b expected 0 0 0", i_gnt, d_gnt, mem_en);
        end
    endtask

    task automatic test_fetch_only();
        do_store(32'h0, 32'hA000_0000, 4'hF);
        do_store(32'h4, 32'hA000_0001, 4'hF);
        do_store(32'h8, 32'hA000_0002, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_req = 1'b1; i_addr = 32'(4 * k);
            #1;
            checks++;
            if (i_gnt !== 1'b1 || mem_addr !== 32'(4 * k) || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL fetch_gnt[%0d]: i_gnt=%b mem_addr=%h mem_we=%b", k, i_gnt, mem_addr, mem_we);
            end
            @(posedge clk); #1;
            checks++;
            if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== (32'hA000_0000 + 32'(k))) begin
                failures++;
                $display("FAIL fetch_data[%0d]: i_rvalid=%b d_rvalid=%b i_rdata=%h expected 1 0 %h",
                         k, i_rvalid, d_rvalid, i_rdata, 32'hA000_0000 + 32'(k));
            end
        end
        @(negedge clk);
        i_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_drain: i_rvalid=%b expected 0", i_rvalid);
        end
    endtask

    task automatic test_store_load();
        do_store(32'h100, 32'h1122_3344, 4'hF);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_drive: d_gnt=%b mem_we=%b mem_be=%b mem_wdata=%h", d_gnt, mem_we, mem_be, mem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL store_no_rvalid: d_rvalid=%b i_rvalid=%b expected 0 0", d_rvalid, i_rvalid);
        end
        @(negedge clk);
        d_we = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL load_drive: mem_we=%b mem_be=%b mem_addr=%h expected 0 1111 100", mem_we, mem_be, mem_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122_BEEF) begin
            failures++;
            $display("FAIL load_data: d_rvalid=%b d_rdata=%h expected 1 1122beef", d_rvalid, d_rdata);
        end
        @(negedge clk);
        d_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL load_drain: d_rvalid=%b expected 0", d_rvalid);
        end
    endtask

    task automatic test_contention();
        logic [11:0] exp_i;
        exp_i = 12'b0010_0001_0000;
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            i_req = 1'b1; i_addr = 32'h0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
            #1;
            checks++;
            if (i_gnt !== exp_i[c] || d_gnt !== !exp_i[c]) begin
                failures++;
                $display("FAIL contention_gnt[%0d]: i_gnt=%b d_gnt=%b expected i_gnt=%b", c, i_gnt, d_gnt, exp_i[c]);
            end
            @(posedge clk); #1;
            if (i_rvalid !== exp_i[c] || d_rvalid !== !exp_i[c]) begin
                failures++;
                $display("FAIL contention_rvalid[%0d]: i_rvalid=%b d_rvalid=%b expected i_rvalid=%b",
                         c, i_rvalid, d_rvalid, exp_i[c]);
            end
            checks++;
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (conflicts !== 4'd12) begin
            failures++;
            $display("FAIL contention_count: conflicts=%0d expected 12", conflicts);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_req = 1'b1; i_addr = 32'h0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || conflicts !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid: d_rvalid=%b i_rvalid=%b conflicts=%0d expected 0 0 0",
                     d_rvalid, i_rvalid, conflicts);
        end
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt);
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int expc;
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            @(posedge clk); #1;
            expc = (k > 15) ? 15 : k;
            checks++;
            if (conflicts !== 4'(expc)) begin
                failures++;
                $display("FAIL saturate[%0d]: conflicts=%0d expected %0d", k, conflicts, expc);
            end
        end
        @(negedge clk);
        perf_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (conflicts !== 4'd0) begin
            failures++;
            $display("FAIL perf_clr: conflicts=%0d expected 0", conflicts);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_be = 4'hF;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL b2b_store: d_gnt=%b mem_we=%b expected 1 1", d_gnt, mem_we);
        end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        i_req = 1'b1; i_addr = 32'h200;
        #1;
        checks++;
        if (i_gnt !== 1'b1 || d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_fetch_gnt: i_gnt=%b d_rvalid=%b i_rvalid=%b expected 1 0 0", i_gnt, d_rvalid, i_rvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL b2b_fetch_data: i_rvalid=%b d_rvalid=%b i_rdata=%h expected 1 0 12345678",
                     i_rvalid, d_rvalid, i_rdata);
        end
        @(negedge clk);
        i_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
